// File: rtl/mem_stream_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_stream_reader
// Purpose  : Read-side sequencer for a single-ported memory with one-cycle
//            read latency. A start command walks `length` consecutive
//            addresses from `base_addr` (wrapping at DEPTH-1) and presents
//            the words as a valid/ready stream with full backpressure. A
//            2-entry FIFO absorbs the read latency, which allows one word
//            per cycle when the consumer never stalls.
// Ports    : clock, reset            - clock, synchronous active-high reset
//            start, base_addr, length - command (sampled only while idle)
//            busy, done               - command status / completion pulse
//            mem_rdaddress, mem_rden  - memory read port
//            mem_q                    - memory read data (one cycle latency)
//            out_data, out_valid, out_ready, out_last - output stream
// Revision : 1.0 - initial release
// ============================================================================
module mem_stream_reader #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 64,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      length,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    mem_rdaddress,
    output logic             mem_rden,
    input  logic [WIDTH-1:0] mem_q,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    localparam logic [AW-1:0] C_LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   C_ONE       = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [AW-1:0]    r_addr;          // next address to read
    logic [AW:0]      r_issue_left;    // reads still to issue
    logic [AW:0]      r_beats_left;    // beats still to hand over
    logic             r_inflight;      // read issued last cycle
    logic             r_done;

    logic [WIDTH-1:0] r_fifo [0:1];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;

    logic             w_rden;
    logic             w_accept;
    logic             w_pop;
    logic             w_push;
    logic             w_final_beat;
    logic [AW-1:0]    w_addr_inc;

    assign w_accept     = (r_state == S_IDLE) && start;
    assign out_valid    = (r_count != 2'd0);
    assign w_pop        = out_valid && out_ready;
    // Every read issued last cycle returns now; the issue rule reserved a slot.
    assign w_push       = r_inflight;
    assign w_final_beat = w_pop && (r_beats_left == C_ONE);
    assign w_addr_inc   = (r_addr == C_LAST_ADDR) ? '0 : r_addr + AW'(1);

    // Next-state and read-issue decode.
    always_comb begin
        w_state_next = r_state;
        w_rden       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (length != '0)) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // Issue when a free slot exists for the returning word, or
                // when a pop this cycle frees one.
                w_rden = (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2) || w_pop;
                if (w_rden && (r_issue_left == C_ONE)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_final_beat) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_issue_left <= '0;
            r_beats_left <= '0;
            r_inflight   <= 1'b0;
            r_done       <= 1'b0;
            r_fifo[0]    <= '0;
            r_fifo[1]    <= '0;
            r_rd_ptr     <= 1'b0;
            r_wr_ptr     <= 1'b0;
            r_count      <= 2'd0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_rden;
            // Zero-length commands complete immediately with no beats.
            r_done     <= (w_accept && (length == '0)) || w_final_beat;

            if (w_accept) begin
                r_addr       <= base_addr;
                r_issue_left <= length;
                r_beats_left <= length;
            end else begin
                if (w_rden) begin
                    r_addr       <= w_addr_inc;
                    r_issue_left <= r_issue_left - C_ONE;
                end
                if (w_pop) begin
                    r_beats_left <= r_beats_left - C_ONE;
                end
            end

            if (w_push) begin
                r_fifo[r_wr_ptr] <= mem_q;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign mem_rden      = w_rden;
    assign mem_rdaddress = r_addr;
    assign out_data      = r_fifo[r_rd_ptr];
    assign out_last      = out_valid && (r_beats_left == C_ONE);

endmodule
`default_nettype wire

// File: tb/tb_mem_stream_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_stream_reader
// Purpose  : Directed self-checking bench for mem_stream_reader. A behavioural
//            one-cycle-latency memory (mem[i] = i+16) feeds the DUT; each
//            directed step checks outputs against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stream_reader;

    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [AW:0]      length;
    logic             busy;
    logic             done;
    logic [AW-1:0]    mem_rdaddress;
    logic             mem_rden;
    logic [WIDTH-1:0] mem_q;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    mem_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .mem_rdaddress (mem_rdaddress),
        .mem_rden      (mem_rden),
        .mem_q         (mem_q),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last)
    );

    always #5 clock = ~clock;

    logic [WIDTH-1:0] tb_mem [0:DEPTH-1];
    always @(posedge clock) begin
        if (mem_rden) mem_q <= tb_mem[mem_rdaddress];
    end

    int checks   = 0;
    int failures = 0;
    int addr_q[$];
    int data_q[$];
    int last_q[$];
    int done_cnt;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int got[$], input int exp[$]);
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : -1, exp[i]);
        end
    endtask

    task automatic clear_q();
        addr_q.delete();
        data_q.delete();
        last_q.delete();
        done_cnt = 0;
    endtask

    // One cycle: drive inputs at the falling edge, let them settle, record.
    task automatic cyc(input logic st, input int b, input int l, input logic rdy);
        @(negedge clock);
        start     = st;
        base_addr = AW'(b);
        length    = (AW+1)'(l);
        out_ready = rdy;
        #1;
        if (mem_rden) addr_q.push_back(int'(mem_rdaddress));
        if (out_valid && out_ready) begin
            data_q.push_back(int'(out_data));
            last_q.push_back(int'(out_last));
        end
        if (done) done_cnt++;
    endtask

    initial begin
        int e[$];
        int entries, inflight, prev_inflight, prev_rden, prev_pop;
        int prev_valid, prev_ready, prev_data, prev_last, pop;

        for (int i = 0; i < DEPTH; i++) tb_mem[i] = WIDTH'(i + 16);
        mem_q     = '0;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b0;
        clear_q();

        // ---------------- reset state ----------------
        repeat (3) @(negedge clock);
        #1;
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(done), 0);
        check("rst_rden",  int'(mem_rden), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_last",  int'(out_last), 0);
        check("rst_addr",  int'(mem_rdaddress), 0);
        check("rst_data",  int'(out_data), 0);
        reset = 1'b0;

        // ---------------- basic burst: base=4, length=5 ----------------
        clear_q();
        cyc(1'b1, 4, 5, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            cyc(1'b0, 0, 0, 1'b1);
            check($sformatf("t1_rden_c%0d", c), int'(mem_rden), (c <= 5) ? 1 : 0);
            if (c <= 5) check($sformatf("t1_addr_c%0d", c), int'(mem_rdaddress), 3 + c);
            check($sformatf("t1_valid_c%0d", c), int'(out_valid), (c >= 3 && c <= 7) ? 1 : 0);
            if (c >= 3 && c <= 7) check($sformatf("t1_data_c%0d", c), int'(out_data), 17 + c);
            check($sformatf("t1_last_c%0d", c), int'(out_last), (c == 7) ? 1 : 0);
            check($sformatf("t1_done_c%0d", c), int'(done), (c == 8) ? 1 : 0);
            check($sformatf("t1_busy_c%0d", c), int'(busy), (c <= 7) ? 1 : 0);
        end

        // ---------------- zero length ----------------
        clear_q();
        cyc(1'b1, 5, 0, 1'b1);
        cyc(1'b0, 0, 0, 1'b1);
        check("t4z_done",  int'(done), 1);
        check("t4z_valid", int'(out_valid), 0);
        check("t4z_busy",  int'(busy), 0);
        check("t4z_rden",  int'(mem_rden), 0);
        cyc(1'b0, 0, 0, 1'b1);
        check("t4z_done_once", int'(done), 0);
        check("t4z_no_beats", data_q.size(), 0);

        // ---------------- start ignored while busy ----------------
        clear_q();
        cyc(1'b1, 0, 3, 1'b1);
        cyc(1'b0, 0, 0, 1'b1);
        cyc(1'b1, 30, 7, 1'b1);
        repeat (10) cyc(1'b0, 0, 0, 1'b1);
        e = '{0, 1, 2};
        check_seq("t4i_addr", addr_q, e);
        e = '{16, 17, 18};
        check_seq("t4i_data", data_q, e);
        check("t4i_done_cnt", done_cnt, 1);

        // ---------------- wrap-around: base=62, length=4 ----------------
        clear_q();
        cyc(1'b1, 62, 4, 1'b1);
        repeat (8) cyc(1'b0, 0, 0, 1'b1);
        e = '{62, 63, 0, 1};
        check_seq("t2_addr", addr_q, e);
        e = '{78, 79, 16, 17};
        check_seq("t2_data", data_q, e);
        e = '{0, 0, 0, 1};
        check_seq("t2_last", last_q, e);
        check("t2_done_cnt", done_cnt, 1);

        // ---------------- backpressure: base=10, length=6, ready 1,0,0 ----------------
        clear_q();
        entries = 0; prev_inflight = 0; prev_rden = 0; prev_pop = 0;
        prev_valid = 0; prev_ready = 0; prev_data = 0; prev_last = 0;
        cyc(1'b1, 10, 6, 1'b1);
        for (int k = 1; k < 60 && done_cnt == 0; k++) begin
            cyc(1'b0, 0, 0, (k % 3) == 0);
            pop      = int'(out_valid && out_ready);
            inflight = prev_rden;
            entries  = entries + prev_inflight - prev_pop;
            check($sformatf("t3_valid_k%0d", k), int'(out_valid), (entries > 0) ? 1 : 0);
            check($sformatf("t3_rden_rule_k%0d", k),
                  int'(!mem_rden || pop == 1 || (entries + inflight) < 2), 1);
            if (prev_valid == 1 && prev_ready == 0) begin
                check($sformatf("t3_hold_valid_k%0d", k), int'(out_valid), 1);
                check($sformatf("t3_hold_data_k%0d", k), int'(out_data), prev_data);
                check($sformatf("t3_hold_last_k%0d", k), int'(out_last), prev_last);
            end
            prev_inflight = inflight;
            prev_rden     = int'(mem_rden);
            prev_pop      = pop;
            prev_valid    = int'(out_valid);
            prev_ready    = int'(out_ready);
            prev_data     = int'(out_data);
            prev_last     = int'(out_last);
        end
        check("t3_done_cnt", done_cnt, 1);
        e = '{26, 27, 28, 29, 30, 31};
        check_seq("t3_data", data_q, e);
        e = '{0, 0, 0, 0, 0, 1};
        check_seq("t3_last", last_q, e);

        // ---------------- back-to-back: start in the done cycle ----------------
        clear_q();
        cyc(1'b1, 40, 3, 1'b1);
        repeat (5) cyc(1'b0, 0, 0, 1'b1);
        cyc(1'b1, 50, 2, 1'b1);
        check("t6_done_c6", int'(done), 1);
        check("t6_busy_c6", int'(busy), 0);
        cyc(1'b0, 0, 0, 1'b1);
        check("t6_rden_c7", int'(mem_rden), 1);
        check("t6_addr_c7", int'(mem_rdaddress), 50);
        check("t6_busy_c7", int'(busy), 1);
        repeat (6) cyc(1'b0, 0, 0, 1'b1);
        e = '{40, 41, 42, 50, 51};
        check_seq("t6_addr", addr_q, e);
        e = '{56, 57, 58, 66, 67};
        check_seq("t6_data", data_q, e);
        check("t6_done_cnt", done_cnt, 2);

        // ---------------- reset mid-burst: base=20, length=8 ----------------
        clear_q();
        cyc(1'b1, 20, 8, 1'b1);
        repeat (4) cyc(1'b0, 0, 0, 1'b1);
        check("t5_beats_before", data_q.size(), 2);
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clock);
        #1;
        check("t5_busy",  int'(busy), 0);
        check("t5_done",  int'(done), 0);
        check("t5_rden",  int'(mem_rden), 0);
        check("t5_valid", int'(out_valid), 0);
        check("t5_last",  int'(out_last), 0);
        check("t5_addr",  int'(mem_rdaddress), 0);
        check("t5_data",  int'(out_data), 0);
        reset = 1'b0;
        clear_q();
        repeat (5) cyc(1'b0, 0, 0, 1'b1);
        check("t5_no_done",  done_cnt, 0);
        check("t5_no_beats", data_q.size(), 0);
        clear_q();
        cyc(1'b1, 0, 2, 1'b1);
        repeat (6) cyc(1'b0, 0, 0, 1'b1);
        e = '{16, 17};
        check_seq("t5_new_data", data_q, e);
        e = '{0, 1};
        check_seq("t5_new_last", last_q, e);
        check("t5_new_done_cnt", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
